exarbiter: RTL and testbench

- Two-requester packet arbiter for the exbus transmit word stream.
- Shares one 35-bit word path between the bus-response encoder (port A, high priority) and the console/stream encoder (port B).
- Holds the grant for a whole packet, which ends on a word with last set. Bounds starvation of B with a burst counter.
- Output feeds the idle/flag inserter with the same stb/busy/last handshake.

---
 rtl/exbus_pkg.sv | 31 +++
 rtl/exarbiter_if.sv | 13 +
 rtl/exarb_grant.sv | 51 +++++
 rtl/exarbiter.sv | 141 ++++++++++++++
 tb/tb_exarbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exbus_pkg.sv
// Shared exbus definitions: word layout, special-word code, owner codes and arbiter state.
package exbus_pkg;

  localparam int WORD_W = 35;
  localparam logic [1:0] SPECIAL_CODE = 2'b11;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10
  } arb_state_e;

  function automatic logic is_special(input logic [WORD_W-1:0] word);
    return (word[WORD_W-1 -: 2] == SPECIAL_CODE);
  endfunction

  function automatic logic [1:0] owner_of(input arb_state_e st);
    logic [1:0] own;
    case (st)
      ST_OWN_A: own = OWN_A;
      ST_OWN_B: own = OWN_B;
      default:  own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/exarbiter_if.sv
// exbus word-stream link: stb/word/last travel forward, busy travels back.
interface exarbiter_if;
  import exbus_pkg::*;

  logic              stb;
  logic [WORD_W-1:0] word;
  logic              last;
  logic              busy;

  modport master (output stb, output word, output last, input busy);
  modport slave  (input stb, input word, input last, output busy);

endinterface

// File: rtl/exarb_grant.sv
// Winner select for an idle arbiter plus the burst counter that bounds starvation of B.
module exarb_grant #(
  parameter int LGBURST = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_a_stb,
  input  logic i_b_stb,
  input  logic i_a_done,
  input  logic i_b_done,
  output logic o_pick_a,
  output logic o_pick_b
);

  localparam logic [LGBURST-1:0] BURST_MAX = {LGBURST{1'b1}};
  localparam logic [LGBURST-1:0] BURST_ONE = LGBURST'(1);

  logic [LGBURST-1:0] count_q, count_d;

  // A keeps winning until B has watched BURST_MAX A packets go by
  always_comb begin
    o_pick_a = i_a_stb && (!i_b_stb || (count_q != BURST_MAX));
    o_pick_b = !o_pick_a && i_b_stb;
  end

  always_comb begin
    count_d = count_q;
    if (i_b_done) begin
      count_d = {LGBURST{1'b0}};
    end else if (i_a_done) begin
      if (!i_b_stb) begin
        count_d = {LGBURST{1'b0}};
      end else if (count_q != BURST_MAX) begin
        count_d = count_q + BURST_ONE;
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= {LGBURST{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/exarbiter.sv
// Two-port packet arbiter for the exbus transmit stream (A high priority, B burst-protected).
// Optional mid-packet stall watchdog enabled by defining EXARB_TIMEOUT_EN.
module exarbiter
  import exbus_pkg::*;
#(
  parameter int LGBURST = 3,
  parameter int LGSTALL = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  exarbiter_if.slave  a,
  exarbiter_if.slave  b,
  exarbiter_if.master out,
  output logic [1:0]  o_owner,
  output logic        o_abort
);

  arb_state_e        state_q, state_d;
  logic              stb_q, stb_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              last_q, last_d;

  logic pick_a, pick_b, grant_a, grant_b, out_free;
  logic a_take, b_take, a_done, b_done, stall_ovf;

  exarb_grant #(.LGBURST(LGBURST)) u_grant (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_a_stb  (a.stb),
    .i_b_stb  (b.stb),
    .i_a_done (a_done),
    .i_b_done (b_done),
    .o_pick_a (pick_a),
    .o_pick_b (pick_b)
  );

  // Idle grants come straight from the winner select so the first word moves this cycle
  always_comb begin
    out_free = !stb_q || !out.busy;
    case (state_q)
      ST_IDLE:  begin grant_a = pick_a; grant_b = pick_b; end
      ST_OWN_A: begin grant_a = 1'b1;   grant_b = 1'b0;   end
      ST_OWN_B: begin grant_a = 1'b0;   grant_b = 1'b1;   end
      default:  begin grant_a = 1'b0;   grant_b = 1'b0;   end
    endcase
    a_take = grant_a && a.stb && out_free;
    b_take = grant_b && b.stb && out_free;
    a_done = a_take && a.last;
    b_done = b_take && b.last;
    a.busy = !grant_a || !out_free;
    b.busy = !grant_b || !out_free;
  end

  always_comb begin
    stb_d  = stb_q;
    word_d = word_q;
    last_d = last_q;
    if (out_free) begin
      stb_d = a_take || b_take;
      if (a_take) begin
        word_d = a.word;
        last_d = a.last;
      end else if (b_take) begin
        word_d = b.word;
        last_d = b.last;
      end else begin
        word_d = word_q;
        last_d = last_q;
      end
    end else begin
      stb_d = stb_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (a_take && !a.last) begin
          state_d = ST_OWN_A;
        end else if (b_take && !b.last) begin
          state_d = ST_OWN_B;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_A: state_d = (a_done || stall_ovf) ? ST_IDLE : ST_OWN_A;
      ST_OWN_B: state_d = (b_done || stall_ovf) ? ST_IDLE : ST_OWN_B;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      stb_q   <= 1'b0;
      word_q  <= {WORD_W{1'b0}};
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      word_q  <= word_d;
      last_q  <= last_d;
    end
  end

`ifdef EXARB_TIMEOUT_EN
  logic [LGSTALL-1:0] stall_q, stall_d;
  logic               abort_q;
  logic               owner_idle;

  // Counts owner-silent cycles; a held output word is left untouched on release
  always_comb begin
    owner_idle = ((state_q == ST_OWN_A) && !a.stb) || ((state_q == ST_OWN_B) && !b.stb);
    stall_ovf  = owner_idle && (stall_q == {LGSTALL{1'b1}});
    if (owner_idle && !stall_ovf) begin
      stall_d = stall_q + LGSTALL'(1);
    end else begin
      stall_d = {LGSTALL{1'b0}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_q <= {LGSTALL{1'b0}};
      abort_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort_q <= stall_ovf;
    end
  end

  assign o_abort = abort_q;
`else
  assign stall_ovf = 1'b0;
  assign o_abort   = 1'b0;
`endif

  assign out.stb  = stb_q;
  assign out.word = word_q;
  assign out.last = last_q;
  assign o_owner  = owner_of(state_q);

endmodule

// File: tb/tb_exarbiter.sv
// Directed scenarios plus a randomised run scored against a packet-level arbitration model.
module tb_exarbiter;
  import exbus_pkg::*;

  localparam int LGB   = 3;
  localparam int BURST = 7;
  localparam int NA    = 24;
  localparam int NB    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] owner;
  logic       abort;

  int checks = 0;
  int errors = 0;

  exarbiter_if a_if ();
  exarbiter_if b_if ();
  exarbiter_if o_if ();

  exarbiter #(.LGBURST(LGB), .LGSTALL(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .a       (a_if),
    .b       (b_if),
    .out     (o_if),
    .o_owner (owner),
    .o_abort (abort)
  );

  always #5 clk = ~clk;

  logic [34:0] a_words [NA][4];
  logic [34:0] b_words [NB][4];
  int          a_len [NA];
  int          b_len [NB];
  logic [35:0] exp_q [$];
  logic [35:0] got;
  logic [36:0] held;
  logic        hold_prev, a_fire, b_fire, o_fire, a_s, b_s;
  int          na, nb, bc, ia, ib, a_pi, a_wi, b_pi, b_wi, wcount;
  logic [34:0] wtmp, exp_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic s, input logic [34:0] w, input logic l);
    a_if.stb = s; a_if.word = w; a_if.last = l;
  endtask

  task automatic drv_b(input logic s, input logic [34:0] w, input logic l);
    b_if.stb = s; b_if.word = w; b_if.last = l;
  endtask

  task automatic edge_();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv_a(1'b0, 35'h0, 1'b0);
    drv_b(1'b0, 35'h0, 1'b0);
    o_if.busy = 1'b0;
    @(negedge clk);
    edge_();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_stb", o_if.stb, 1'b0);
    chk("rst_word", o_if.word, 35'h0);
    chk("rst_last", o_if.last, 1'b0);
    chk("rst_owner", owner, 2'b00);
    chk("rst_abort", abort, 1'b0);

    // A three-word packet, B idle
    for (int k = 0; k < 3; k++) begin
      drv_a(1'b1, 35'h1_0000_0001 + 35'(k), (k == 2));
      #1;
      chk("t1_a_busy", a_if.busy, 1'b0);
      chk("t1_b_busy", b_if.busy, 1'b1);
      edge_();
      chk("t1_stb", o_if.stb, 1'b1);
      chk("t1_word", o_if.word, 35'h1_0000_0001 + 35'(k));
      chk("t1_last", o_if.last, (k == 2));
      chk("t1_owner", owner, (k == 2) ? 2'b00 : 2'b01);
    end
    drv_a(1'b0, 35'h0, 1'b0);

    // both request single-word packets: seven A then one B
    do_reset();
    na = 0; nb = 0;
    for (int p = 0; p < 16; p++) begin
      drv_a(1'b1, 35'h1_0000_0000 | 35'(na), 1'b1);
      drv_b(1'b1, 35'h2_0000_0000 | 35'(nb), 1'b1);
      #1;
      a_fire = !a_if.busy;
      b_fire = !b_if.busy;
      edge_();
      if (a_fire) na++;
      if (b_fire) nb++;
      if (p % 8 == 7) exp_w = 35'h2_0000_0000 | 35'(p / 8);
      else            exp_w = 35'h1_0000_0000 | 35'(p - p / 8);
      chk("t2_word", o_if.word, exp_w);
      chk("t2_stb", o_if.stb, 1'b1);
    end
    drv_a(1'b0, 35'h0, 1'b0);
    drv_b(1'b0, 35'h0, 1'b0);

    // B owns mid-packet when A arrives
    do_reset();
    drv_b(1'b1, 35'h2_0000_0B01, 1'b0); edge_();
    chk("t3_w1", o_if.word, 35'h2_0000_0B01);
    chk("t3_own", owner, 2'b10);
    drv_b(1'b1, 35'h2_0000_0B02, 1'b0); edge_();
    chk("t3_w2", o_if.word, 35'h2_0000_0B02);
    drv_b(1'b1, 35'h2_0000_0B03, 1'b0);
    drv_a(1'b1, 35'h1_0000_0A01, 1'b1);
    #1; chk("t3_a_busy3", a_if.busy, 1'b1);
    edge_();
    chk("t3_w3", o_if.word, 35'h2_0000_0B03);
    drv_b(1'b1, 35'h2_0000_0B04, 1'b1);
    #1; chk("t3_a_busy4", a_if.busy, 1'b1);
    edge_();
    chk("t3_w4", o_if.word, 35'h2_0000_0B04);
    chk("t3_last4", o_if.last, 1'b1);
    drv_b(1'b0, 35'h0, 1'b0);
    #1; chk("t3_a_free", a_if.busy, 1'b0);
    edge_();
    chk("t3_a_word", o_if.word, 35'h1_0000_0A01);
    drv_a(1'b0, 35'h0, 1'b0);

    // downstream stall for five cycles
    do_reset();
    drv_a(1'b1, 35'h1_0000_00C1, 1'b1); edge_();
    chk("t4_x", o_if.word, 35'h1_0000_00C1);
    drv_a(1'b1, 35'h1_0000_00C2, 1'b1);
    drv_b(1'b1, 35'h2_0000_00C3, 1'b1);
    o_if.busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_a_busy", a_if.busy, 1'b1);
      chk("t4_b_busy", b_if.busy, 1'b1);
      edge_();
      chk("t4_hold_stb", o_if.stb, 1'b1);
      chk("t4_hold_word", o_if.word, 35'h1_0000_00C1);
      chk("t4_hold_last", o_if.last, 1'b1);
    end
    o_if.busy = 1'b0;
    edge_();
    chk("t4_y", o_if.word, 35'h1_0000_00C2);
    drv_a(1'b0, 35'h0, 1'b0);
    edge_();
    chk("t4_z", o_if.word, 35'h2_0000_00C3);
    drv_b(1'b0, 35'h0, 1'b0);
    edge_();
    chk("t4_drained", o_if.stb, 1'b0);

    // owner goes silent mid-packet while B waits
    do_reset();
    drv_a(1'b1, 35'h1_0000_00A1, 1'b0); edge_();
    drv_a(1'b0, 35'h0, 1'b0);
    drv_b(1'b1, 35'h2_0000_00B1, 1'b1);
`ifdef EXARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      chk("t5_no_abort", abort, 1'b0);
      chk("t5_owner_a", owner, 2'b01);
      #1; chk("t5_b_wait", b_if.busy, 1'b1);
      edge_();
    end
    chk("t5_abort", abort, 1'b1);
    chk("t5_idle", owner, 2'b00);
    #1; chk("t5_b_grant", b_if.busy, 1'b0);
    edge_();
    drv_b(1'b0, 35'h0, 1'b0);
    chk("t5_abort_pulse", abort, 1'b0);
    chk("t5_b_word", o_if.word, 35'h2_0000_00B1);
    chk("t5_b_stb", o_if.stb, 1'b1);
`else
    for (int k = 1; k <= 20; k++) begin
      chk("t5_no_abort", abort, 1'b0);
      chk("t5_owner_a", owner, 2'b01);
      #1; chk("t5_b_wait", b_if.busy, 1'b1);
      edge_();
    end
    drv_a(1'b1, 35'h1_0000_00A2, 1'b1);
    edge_();
    drv_a(1'b0, 35'h0, 1'b0);
    chk("t5_a2", o_if.word, 35'h1_0000_00A2);
    edge_();
    drv_b(1'b0, 35'h0, 1'b0);
    chk("t5_b_word", o_if.word, 35'h2_0000_00B1);
`endif

    // reset while B owns a packet
    do_reset();
    drv_b(1'b1, 35'h2_0000_0C01, 1'b0); edge_();
    chk("t6_own_b", owner, 2'b10);
    drv_b(1'b1, 35'h2_0000_0C02, 1'b0);
    rst = 1'b1;
    edge_();
    rst = 1'b0;
    drv_b(1'b0, 35'h0, 1'b0);
    chk("t6_stb", o_if.stb, 1'b0);
    chk("t6_owner", owner, 2'b00);
    drv_a(1'b1, 35'h1_0000_0D01, 1'b1); edge_();
    drv_a(1'b0, 35'h0, 1'b0);
    chk("t6_a_stb", o_if.stb, 1'b1);
    chk("t6_a_word", o_if.word, 35'h1_0000_0D01);
    chk("t6_a_last", o_if.last, 1'b1);
    chk("t6_a_owner", owner, 2'b00);

    // randomised packets, ordering predicted at packet level
    wcount = 0;
    for (int i = 0; i < NA; i++) begin
      a_len[i] = $urandom_range(1, 4);
      for (int w = 0; w < 4; w++) begin
        wtmp = {3'($urandom), 32'($urandom)};
        if (wcount % 3 == 0) wtmp[34:33] = SPECIAL_CODE;
        a_words[i][w] = wtmp;
        wcount++;
      end
    end
    for (int i = 0; i < NB; i++) begin
      b_len[i] = $urandom_range(1, 4);
      for (int w = 0; w < 4; w++) begin
        wtmp = {3'($urandom), 32'($urandom)};
        if (wcount % 3 == 0) wtmp[34:33] = SPECIAL_CODE;
        b_words[i][w] = wtmp;
        wcount++;
      end
    end
    bc = 0; ia = 0; ib = 0;
    while (ia < NA || ib < NB) begin
      if (ia < NA && (ib >= NB || bc < BURST)) begin
        for (int w = 0; w < a_len[ia]; w++) exp_q.push_back({(w == a_len[ia] - 1), a_words[ia][w]});
        bc = (ib < NB) ? ((bc < BURST) ? bc + 1 : bc) : 0;
        ia++;
      end else begin
        for (int w = 0; w < b_len[ib]; w++) exp_q.push_back({(w == b_len[ib] - 1), b_words[ib][w]});
        bc = 0;
        ib++;
      end
    end

    do_reset();
    a_pi = 0; a_wi = 0; b_pi = 0; b_wi = 0;
    a_s = 1'b0; b_s = 1'b0; a_fire = 1'b0; b_fire = 1'b0; hold_prev = 1'b0; held = 37'h0;
    for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
      if (a_pi >= NA) a_s = 1'b0;
      else if (!a_s || a_fire) a_s = (a_wi == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (b_pi >= NB) b_s = 1'b0;
      else if (!b_s || b_fire) b_s = (b_wi == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (a_pi < NA) drv_a(a_s, a_words[a_pi][a_wi], (a_wi == a_len[a_pi] - 1));
      else           drv_a(1'b0, 35'h0, 1'b0);
      if (b_pi < NB) drv_b(b_s, b_words[b_pi][b_wi], (b_wi == b_len[b_pi] - 1));
      else           drv_b(1'b0, 35'h0, 1'b0);
      o_if.busy = ($urandom_range(0, 9) < 3);
      #1;
      a_fire = a_s && !a_if.busy;
      b_fire = b_s && !b_if.busy;
      o_fire = o_if.stb && !o_if.busy;
      if (hold_prev) chk("rand_hold", {o_if.stb, o_if.last, o_if.word}, held);
      if (o_fire) begin
        got = exp_q.pop_front();
        chk("rand_word", o_if.word, got[34:0]);
        chk("rand_last", o_if.last, got[35]);
      end
      hold_prev = o_if.stb && o_if.busy;
      held = {o_if.stb, o_if.last, o_if.word};
      edge_();
      if (a_fire) begin
        a_wi++;
        if (a_wi == a_len[a_pi]) begin a_pi++; a_wi = 0; end
      end
      if (b_fire) begin
        b_wi++;
        if (b_wi == b_len[b_pi]) begin b_pi++; b_wi = 0; end
      end
    end
    chk("rand_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
